// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_pkg
//  Brief    : Shared PPU types and constants for the OAM sprite search.
//             Holds the sprite buffer entry layout and the line-match helper.
//  Revision : 1.0  initial release
// ============================================================================
package ppu_pkg;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_ENTRIES  = 40;
  localparam int          OBJ_LINE_MAX = 10;
  localparam int          MODE2_CYCLES = 80;

  typedef struct packed {
    logic [7:0] x;
    logic [3:0] row;
    logic [5:0] oam_idx;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Returns {hit, row}. Everything is 9-bit so that Y+16 and LY+16 never wrap.
  function automatic logic [4:0] obj_match(input logic [7:0] ly,
                                           input logic [7:0] y,
                                           input logic       tall);
    logic [8:0] line;
    logic [8:0] top;
    logic [8:0] bottom;
    logic [3:0] row;
    line   = {1'b0, ly} + 9'd16;
    top    = {1'b0, y};
    bottom = top + (tall ? 9'd16 : 9'd8);
    row    = 4'(line - top);
    return {(line >= top) && (line < bottom), row};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_oam_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_oam_scan_if
//  Brief    : OAM RAM read port seen by the sprite search. The scanner is the
//             master (issues strobe and address), OAM RAM is the slave and
//             returns {X, Y} one cycle after the strobe.
//  Revision : 1.0  initial release
// ============================================================================
interface ppu_oam_scan_if;
  logic        oam_rd_en;
  logic [7:0]  oam_addr;
  logic [15:0] oam_rdata;

  modport master (output oam_rd_en, output oam_addr, input  oam_rdata);
  modport slave  (input  oam_rd_en, input  oam_addr, output oam_rdata);
endinterface
`default_nettype wire

// File: rtl/ppu_sprite_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_sprite_buf
//  Brief    : Per-line sprite buffer with clear, push and combinational read.
//             Pushes beyond MAX_SPRITES are ignored.
//             Config macro OAM_SCAN_X_SORT_EN: when defined, each push is an
//             insertion that keeps the slots sorted by X ascending (stable on
//             equal X); otherwise pushes append in discovery order.
//  Revision : 1.0  initial release
// ============================================================================
module ppu_sprite_buf
  import ppu_pkg::*;
#(
  parameter int MAX_SPRITES = OBJ_LINE_MAX
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clear,
  input  wire logic          push,
  input  wire sprite_entry_t push_entry,
  input  wire logic [3:0]    rd_idx,
  output sprite_entry_t      rd_entry,
  output logic [3:0]         count
);

  localparam logic [3:0] C_MAX = 4'(MAX_SPRITES);

  sprite_entry_t slots_q [MAX_SPRITES];
  sprite_entry_t prev    [MAX_SPRITES];
  logic [3:0]    count_q;
  logic [3:0]    ins_pos;
  logic          store;

  assign store = push && (count_q < C_MAX);

  // Neighbour below each slot, used when an insertion shifts entries up.
  for (genvar k = 0; k < MAX_SPRITES; k++) begin : g_prev
    if (k == 0) begin : g_head
      assign prev[k] = '0;
    end else begin : g_tail
      assign prev[k] = slots_q[k-1];
    end
  end

  // Slot the new entry lands in: the tail, or after every stored X <= new X.
  always_comb begin
    ins_pos = count_q;
`ifdef OAM_SCAN_X_SORT_EN
    ins_pos = '0;
    for (int k = 0; k < MAX_SPRITES; k++) begin
      if ((4'(k) < count_q) && (slots_q[k].x <= push_entry.x)) begin
        ins_pos = ins_pos + 4'd1;
      end
    end
`endif
  end

  // Slot storage and fill count; clear wins over push.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
      for (int k = 0; k < MAX_SPRITES; k++) slots_q[k] <= '0;
    end else if (store) begin
      count_q <= count_q + 4'd1;
      for (int k = 0; k < MAX_SPRITES; k++) begin
        if (4'(k) == ins_pos)     slots_q[k] <= push_entry;
        else if (4'(k) > ins_pos) slots_q[k] <= prev[k];
      end
    end
  end

  assign rd_entry = (rd_idx < C_MAX) ? slots_q[rd_idx] : '0;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/ppu_oam_scan.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_oam_scan
//  Brief    : PPU mode-2 sprite search. Walks the 40 OAM entries (read cycle
//             then evaluate cycle each), keeps the first MAX_SPRITES that
//             overlap the latched scanline and exposes them to the fetcher.
//             Config macro OAM_SCAN_X_SORT_EN selects X-sorted buffer order
//             (see ppu_sprite_buf); default is OAM order.
//  Revision : 1.0  initial release
// ============================================================================
module ppu_oam_scan
  import ppu_pkg::*;
#(
  parameter int NUM_ENTRIES = OAM_ENTRIES,
  parameter int MAX_SPRITES = OBJ_LINE_MAX,
  parameter int CYC_PER_ENT = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          start,
  input  wire logic [7:0]    ly,
  input  wire logic          obj_tall,
  input  wire logic          dma_active,
  ppu_oam_scan_if.master     oam,
  output logic               busy,
  output logic               done,
  output logic [3:0]         spr_count,
  input  wire logic [3:0]    rd_idx,
  output sprite_entry_t      rd_entry
);

  localparam int             PH_W     = (CYC_PER_ENT > 2) ? $clog2(CYC_PER_ENT) : 1;
  localparam logic [PH_W-1:0] LAST_PH  = PH_W'(CYC_PER_ENT - 1);
  localparam logic [PH_W-1:0] EVAL_PH  = PH_W'(1);
  localparam logic [5:0]     LAST_ENT = 6'(NUM_ENTRIES - 1);

  scan_state_t     state_q, state_d;
  logic [5:0]      ent_q, ent_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [7:0]      ly_q, ly_d;
  logic            tall_q, tall_d;
  logic            buf_clear;
  logic            buf_push;
  logic            eval;
  logic [4:0]      match;
  sprite_entry_t   cand;

  // Scan state, entry counter and the per-line parameters captured at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ent_q   <= '0;
      phase_q <= '0;
      ly_q    <= '0;
      tall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      phase_q <= phase_d;
      ly_q    <= ly_d;
      tall_q  <= tall_d;
    end
  end

  // Data read in the previous cycle is judged here; DMA masks every hit.
  assign eval  = (state_q == ST_SCAN) && (phase_q == EVAL_PH);
  assign match = obj_match(ly_q, oam.oam_rdata[7:0], tall_q);
  assign cand  = '{x: oam.oam_rdata[15:8], row: match[3:0], oam_idx: ent_q};

  // Next state; a start in any state (re)begins the line from entry 0.
  always_comb begin
    state_d   = state_q;
    ent_d     = ent_q;
    phase_d   = phase_q;
    ly_d      = ly_q;
    tall_d    = tall_q;
    buf_clear = 1'b0;
    buf_push  = 1'b0;
    if (start) begin
      state_d   = ST_SCAN;
      ent_d     = '0;
      phase_d   = '0;
      ly_d      = ly;
      tall_d    = obj_tall;
      buf_clear = 1'b1;
    end else begin
      case (state_q)
        ST_SCAN: begin
          buf_push = eval && match[4] && !dma_active;
          if (phase_q == LAST_PH) begin
            phase_d = '0;
            if (ent_q == LAST_ENT) begin
              state_d = ST_DONE;
              ent_d   = '0;
            end else begin
              ent_d = ent_q + 6'd1;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy          = (state_q == ST_SCAN);
  assign done          = (state_q == ST_DONE);
  assign oam.oam_rd_en = (state_q == ST_SCAN) && (phase_q == '0);
  assign oam.oam_addr  = {ent_q, 2'b00};

  ppu_sprite_buf #(
    .MAX_SPRITES (MAX_SPRITES)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clear      (buf_clear),
    .push       (buf_push),
    .push_entry (cand),
    .rd_idx     (rd_idx),
    .rd_entry   (rd_entry),
    .count      (spr_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ppu_oam_scan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ppu_oam_scan
//  Brief    : Directed bench for the sprite search. Each tracked scan pushes
//             its expected done cycle, count and buffer image; a monitor pops
//             and compares whenever done pulses. Honours OAM_SCAN_X_SORT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppu_oam_scan;
  import ppu_pkg::*;

  typedef struct {
    int               done_cyc;
    int               count;
    logic [9:0][17:0] ents;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    ly;
  logic          obj_tall;
  logic          dma_active;
  logic          busy;
  logic          done;
  logic [3:0]    spr_count;
  logic [3:0]    rd_idx;
  sprite_entry_t rd_entry;

  logic [15:0] mem [40];
  exp_t        sb [$];
  int          cyc       = 0;
  int          vecs      = 0;
  int          errs      = 0;
  int          n_checked = 0;

  ppu_oam_scan_if oam ();

  ppu_oam_scan dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ly         (ly),
    .obj_tall   (obj_tall),
    .dma_active (dma_active),
    .oam        (oam),
    .busy       (busy),
    .done       (done),
    .spr_count  (spr_count),
    .rd_idx     (rd_idx),
    .rd_entry   (rd_entry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // OAM RAM: one cycle read latency, reads return 0xFF while DMA owns it.
  always @(posedge clk)
    if (oam.oam_rd_en) oam.oam_rdata <= dma_active ? 16'hFFFF : mem[oam.oam_addr[7:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [17:0] ent(input int x, input int row, input int idx);
    return {8'(x), 4'(row), 6'(idx)};
  endfunction

  task automatic fill(input int y, input int x);
    for (int i = 0; i < 40; i++) mem[i] = {8'(x), 8'(y)};
  endtask

  task automatic issue(input logic [7:0] l, input logic t, input bit track, input exp_t e);
    @(negedge clk);
    start = 1'b1; ly = l; obj_tall = t;
    if (track) begin
      e.done_cyc = cyc + 81;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_checked(input int target);
    for (int t = 0; t < 300 && n_checked < target; t++) @(negedge clk);
    if (n_checked < target) begin
      vecs++; errs++;
      $display("FAIL done_timeout: actual no done within 300 cycles, required done pulse");
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    rd_idx = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        exp_t e;
        if (sb.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_done: actual done=1 at cycle %0d, required no done", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("busy_in_done", 32'(busy), 32'd0);
          check("spr_count", 32'(spr_count), 32'(e.count));
          for (int k = 0; k < 10; k++) begin
            rd_idx = 4'(k);
            #1;
            check($sformatf("rd_entry[%0d]", k), 32'(rd_entry), 32'(e.ents[k]));
          end
          n_checked++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   tgt;
    rst = 1'b1; start = 1'b0; ly = '0; obj_tall = 1'b0; dma_active = 1'b0;
    fill(0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(oam.oam_rd_en), 32'd0);
    check("rst_addr", 32'(oam.oam_addr), 32'd0);
    check("rst_count", 32'(spr_count), 32'd0);
    check("rst_entry", 32'(rd_entry), 32'd0);

    // ly=0, 8x8: only entry 0 (Y=16, X=8) overlaps, row 0. Also probe strobes.
    fill(0, 0); mem[0] = {8'd8, 8'd16};
    e.ents = '0; e.count = 1; e.ents[0] = ent(8, 0, 0);
    tgt = n_checked + 1;
    issue(8'd0, 1'b0, 1'b1, e);
    check("busy_scan", 32'(busy), 32'd1);
    check("rd_en_e0", 32'(oam.oam_rd_en), 32'd1);
    check("addr_e0", 32'(oam.oam_addr), 32'd0);
    @(negedge clk);
    check("rd_en_eval0", 32'(oam.oam_rd_en), 32'd0);
    @(negedge clk);
    check("rd_en_e1", 32'(oam.oam_rd_en), 32'd1);
    check("addr_e1", 32'(oam.oam_addr), 32'd4);
    wait_checked(tgt);

    // ly=5: all 40 hit (row 5); only the first 10 in OAM order are kept.
    for (int i = 0; i < 40; i++) mem[i] = {8'(i + 1), 8'd16};
    e.ents = '0; e.count = 10;
    for (int k = 0; k < 10; k++) e.ents[k] = ent(k + 1, 5, k);
    tgt = n_checked + 1;
    issue(8'd5, 1'b0, 1'b1, e);
    wait_checked(tgt);

    // ly=20, 8x16, L=36: Y=24 hits row 12; Y=20 misses (L == Y+16);
    // Y=8 and Y=5 end well above the line.
    fill(0, 0);
    mem[3] = {8'd40, 8'd24}; mem[4] = {8'd41, 8'd20};
    mem[5] = {8'd42, 8'd8};  mem[6] = {8'd43, 8'd5};
    e.ents = '0; e.count = 1; e.ents[0] = ent(40, 12, 3);
    tgt = n_checked + 1;
    issue(8'd20, 1'b1, 1'b1, e);
    wait_checked(tgt);

    // ly=250, 8x16, L=266 (9-bit): Y=255 row 11, Y=250 miss, Y=251 row 15
    // with X=0, Y=252 row 14 with X=200 (X never filters).
    fill(0, 0);
    mem[7] = {8'd3, 8'd255}; mem[8] = {8'd5, 8'd250};
    mem[9] = {8'd0, 8'd251}; mem[10] = {8'd200, 8'd252};
    e.ents = '0; e.count = 3;
`ifdef OAM_SCAN_X_SORT_EN
    e.ents[0] = ent(0, 15, 9); e.ents[1] = ent(3, 11, 7); e.ents[2] = ent(200, 14, 10);
`else
    e.ents[0] = ent(3, 11, 7); e.ents[1] = ent(0, 15, 9); e.ents[2] = ent(200, 14, 10);
`endif
    tgt = n_checked + 1;
    issue(8'd250, 1'b1, 1'b1, e);
    wait_checked(tgt);

    // ly=150, 8x8, L=166: Y=160 row 6, Y=159 row 7, Y=158 miss.
    fill(0, 0);
    mem[0] = {8'd9, 8'd160}; mem[1] = {8'd10, 8'd159}; mem[2] = {8'd11, 8'd158};
    e.ents = '0; e.count = 2; e.ents[0] = ent(9, 6, 0); e.ents[1] = ent(10, 7, 1);
    tgt = n_checked + 1;
    issue(8'd150, 1'b0, 1'b1, e);
    wait_checked(tgt);

    // DMA for the whole scan: every entry would hit, none may be kept.
    fill(16, 7);
    dma_active = 1'b1;
    e.ents = '0; e.count = 0;
    tgt = n_checked + 1;
    issue(8'd0, 1'b0, 1'b1, e);
    wait_checked(tgt);
    dma_active = 1'b0;

    // X-order: hits at X=50,20,20,90 (idx 0..3).
    fill(0, 0);
    mem[0] = {8'd50, 8'd16}; mem[1] = {8'd20, 8'd16};
    mem[2] = {8'd20, 8'd16}; mem[3] = {8'd90, 8'd16};
    e.ents = '0; e.count = 4;
`ifdef OAM_SCAN_X_SORT_EN
    e.ents[0] = ent(20, 0, 1); e.ents[1] = ent(20, 0, 2);
    e.ents[2] = ent(50, 0, 0); e.ents[3] = ent(90, 0, 3);
`else
    e.ents[0] = ent(50, 0, 0); e.ents[1] = ent(20, 0, 1);
    e.ents[2] = ent(20, 0, 2); e.ents[3] = ent(90, 0, 3);
`endif
    tgt = n_checked + 1;
    issue(8'd0, 1'b0, 1'b1, e);
    wait_checked(tgt);

    // Restart at cycle 30 of a ly=100 scan (no hits) with ly=3 (all hit, row 3):
    // only the second start may produce a done, 81 cycles after it.
    for (int i = 0; i < 40; i++) mem[i] = {8'(i + 1), 8'd16};
    e.ents = '0; e.count = 0;
    issue(8'd100, 1'b0, 1'b0, e);
    repeat (29) @(negedge clk);
    e.count = 10;
    for (int k = 0; k < 10; k++) e.ents[k] = ent(k + 1, 3, k);
    tgt = n_checked + 1;
    issue(8'd3, 1'b0, 1'b1, e);
    wait_checked(tgt);

    // rst mid-scan: idle with cleared count on the next cycle and no done.
    e.ents = '0; e.count = 0;
    issue(8'd0, 1'b0, 1'b0, e);
    repeat (20) @(negedge clk);
    check("busy_pre_rst", 32'(busy), 32'd1);
    check("count_pre_rst", 32'(spr_count), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("busy_post_rst", 32'(busy), 32'd0);
    check("count_post_rst", 32'(spr_count), 32'd0);
    check("done_post_rst", 32'(done), 32'd0);
    repeat (100) @(negedge clk);
    check("pending_after_rst", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
